// File: rtl/simd_pkg.sv
// Shared opcode and FSM-state definitions for the SIMD sequencer / Processing_Element path.
package simd_pkg;

    localparam int OPW = 3;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_MUL  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_XOR  = 3'd5,
        OP_PASS = 3'd6,
        OP_NOP  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } issue_state_e;

endpackage

// File: rtl/pe_issue_unit.sv
// Issues one decoded SIMD op at a time to a Processing_Element and returns its result.
// Optional PE_DONE watchdog: define PE_ISSUE_TIMEOUT_EN.
module pe_issue_unit #(
    parameter int N           = 16,
    parameter int OPW         = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [OPW-1:0]   IN_OP,
    input  logic [N-1:0]     IN_A,
    input  logic [N-1:0]     IN_B,
    output logic             PE_START,
    output logic [OPW-1:0]   PE_OP,
    output logic [N-1:0]     PE_A,
    output logic [N-1:0]     PE_B,
    output logic             RST_MUL,
    input  logic             PE_DONE,
    input  logic [2*N-1:0]   PE_RESULT,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [2*N-1:0]   OUT_DATA,
    output logic             OUT_ERR
);
    import simd_pkg::*;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    issue_state_e   state_q, state_d;
    logic [OPW-1:0] pe_op_q, pe_op_d;
    logic [N-1:0]   pe_a_q, pe_a_d;
    logic [N-1:0]   pe_b_q, pe_b_d;
    logic [2*N-1:0] out_data_q, out_data_d;
    logic           pe_start_q, pe_start_d;
    logic           rst_mul_q, rst_mul_d;
    logic           done_ok;
    logic           timeout;
    logic           out_err_d;

    // The PE cannot answer in its own launch cycle, so a DONE seen alongside START is noise.
    assign done_ok = PE_DONE && !pe_start_q;

`ifdef PE_ISSUE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            out_err_q;

    // Counter sits at zero outside WAIT, so entering WAIT always starts a fresh count.
    assign to_cnt_d = (state_q == ST_WAIT) ? to_cnt_q + 1'b1 : '0;
    assign timeout  = (state_q == ST_WAIT) && !done_ok
                      && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            to_cnt_q  <= '0;
            out_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            out_err_q <= out_err_d;
        end
    end

    assign OUT_ERR = out_err_q;
`else
    assign timeout = 1'b0;
    assign OUT_ERR = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pe_op_d    = pe_op_q;
        pe_a_d     = pe_a_q;
        pe_b_d     = pe_b_q;
        out_data_d = out_data_q;
        out_err_d  = OUT_ERR;
        pe_start_d = (state_q == ST_ISSUE);
        rst_mul_d  = (state_q == ST_CLR) || timeout;

        case (state_q)
            ST_IDLE: begin
                if (IN_VALID) begin
                    pe_op_d = IN_OP;
                    pe_a_d  = IN_A;
                    pe_b_d  = IN_B;
                    case (op_e'(IN_OP))
                        OP_MUL:  state_d = ST_CLR;
                        OP_NOP: begin
                            state_d    = ST_RESP;
                            out_data_d = '0;
                            out_err_d  = 1'b0;
                        end
                        default: state_d = ST_ISSUE;
                    endcase
                end
            end
            ST_CLR:   state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_ok) begin
                    out_data_d = PE_RESULT;
                    out_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (timeout) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                if (OUT_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            pe_op_q    <= '0;
            pe_a_q     <= '0;
            pe_b_q     <= '0;
            out_data_q <= '0;
            pe_start_q <= 1'b0;
            rst_mul_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pe_op_q    <= pe_op_d;
            pe_a_q     <= pe_a_d;
            pe_b_q     <= pe_b_d;
            out_data_q <= out_data_d;
            pe_start_q <= pe_start_d;
            rst_mul_q  <= rst_mul_d;
        end
    end

    assign IN_READY  = (state_q == ST_IDLE);
    assign OUT_VALID = (state_q == ST_RESP);
    assign PE_START  = pe_start_q;
    assign RST_MUL   = rst_mul_q;
    assign PE_OP     = pe_op_q;
    assign PE_A      = pe_a_q;
    assign PE_B      = pe_b_q;
    assign OUT_DATA  = out_data_q;

endmodule

// File: tb/tb_pe_issue_unit.sv
// Scoreboard bench for pe_issue_unit with a behavioural Processing_Element model.
module tb_pe_issue_unit;
    import simd_pkg::*;

    localparam int N  = 16;
    localparam int TO = 8;

    logic          CLK, RSTN;
    logic          IN_VALID, IN_READY;
    logic [2:0]    IN_OP;
    logic [N-1:0]  IN_A, IN_B;
    logic          PE_START, RST_MUL, PE_DONE;
    logic [2:0]    PE_OP;
    logic [N-1:0]  PE_A, PE_B;
    logic [2*N-1:0] PE_RESULT;
    logic          OUT_VALID, OUT_READY, OUT_ERR;
    logic [2*N-1:0] OUT_DATA;

    pe_issue_unit #(.N(N), .OPW(3), .TIMEOUT_CYC(TO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_OP(IN_OP), .IN_A(IN_A), .IN_B(IN_B),
        .PE_START(PE_START), .PE_OP(PE_OP), .PE_A(PE_A), .PE_B(PE_B), .RST_MUL(RST_MUL),
        .PE_DONE(PE_DONE), .PE_RESULT(PE_RESULT),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_ERR(OUT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    // ---------------- Processing_Element model ----------------
    logic        model_done, stray_done;
    logic [31:0] model_res;
    int          pe_delay = 2;
    bit          pe_mute  = 1'b0;

    assign PE_DONE   = model_done | stray_done;
    assign PE_RESULT = stray_done ? 32'hDEAD_BEEF : model_res;

    function automatic logic [31:0] pe_calc(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return {16'h0, 16'(a + b)};
            3'd1:    return {16'h0, 16'(a - b)};
            3'd2:    return {16'h0, a} * {16'h0, b};
            3'd3:    return {16'h0, a & b};
            3'd4:    return {16'h0, a | b};
            3'd5:    return {16'h0, a ^ b};
            default: return {16'h0, a};
        endcase
    endfunction

    initial begin
        logic [2:0]  m_op;
        logic [15:0] m_a, m_b;
        model_done = 1'b0;
        model_res  = '0;
        forever begin
            @(posedge CLK);
            if (PE_START === 1'b1 && !pe_mute) begin
                m_op = PE_OP;
                m_a  = PE_A;
                m_b  = PE_B;
                for (int i = 1; i < pe_delay; i++) @(posedge CLK);
                #1;
                model_res  = pe_calc(m_op, m_a, m_b);
                model_done = 1'b1;
                @(negedge CLK);
                check("pe_op_hold", PE_OP, m_op);
                check("pe_a_hold",  PE_A,  m_a);
                check("pe_b_hold",  PE_B,  m_b);
                @(posedge CLK);
                #1 model_done = 1'b0;
            end
        end
    end

    // ---------------- Monitor ----------------
    int   acc_cyc = 0, lat = 0, start_cyc = 0, rst_cyc = 0;
    int   n_start = 0, n_rst = 0;
    logic ov_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (PE_START) begin n_start++; start_cyc = cyc; end
            if (RST_MUL)  begin n_rst++;   rst_cyc   = cyc; end
            if (IN_VALID && IN_READY) acc_cyc = cyc;
            if (OUT_VALID && !ov_prev) lat = cyc - acc_cyc;
            if (OUT_VALID && OUT_READY) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out_valid", OUT_VALID, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", OUT_DATA, e.data);
                    check("out_err",  OUT_ERR,  e.err);
                    if (e.lat > 0) check("latency", lat, e.lat);
                end
            end
            ov_prev = OUT_VALID;
        end
    end

    // ---------------- Driver ----------------
    task automatic send_op(input op_e op, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] data, input logic err, input int exp_lat, input bit push);
        exp_t e;
        bit   done = 1'b0;
        if (push) begin
            e.data = data; e.err = err; e.lat = exp_lat;
            sb_q.push_back(e);
        end
        @(posedge CLK); #1;
        IN_VALID = 1'b1; IN_OP = op; IN_A = a; IN_B = b;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge CLK);
            if (IN_READY) begin
                @(posedge CLK); #1;
                IN_VALID = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            check("in_handshake_timeout", IN_READY, 1);
            IN_VALID = 1'b0;
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge CLK);
            if (sb_q.size() == 0 && IN_READY) done = 1'b1;
        end
        if (!done) check("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- Stimulus ----------------
    int s0, r0;

    initial begin
        RSTN = 1'b0; IN_VALID = 1'b0; IN_OP = '0; IN_A = '0; IN_B = '0;
        OUT_READY = 1'b1; stray_done = 1'b0;
        #12;
        check("rst_in_ready",  IN_READY,  1);
        check("rst_pe_start",  PE_START,  0);
        check("rst_rst_mul",   RST_MUL,   0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_err",   OUT_ERR,   0);
        check("rst_out_data",  OUT_DATA,  0);
        check("rst_pe_opab",   {PE_OP, PE_A, PE_B}, 0);
        @(negedge CLK); RSTN = 1'b1;

        // ADD, d=2: latency 3+2
        s0 = n_start; r0 = n_rst;
        send_op(OP_ADD, 16'd5, 16'd3, 32'd8, 1'b0, 5, 1'b1);
        drain();
        check("add_start_cnt", n_start - s0, 1);
        check("add_rstmul_cnt", n_rst - r0, 0);

        // MUL, d=2: extra CLR cycle
        s0 = n_start; r0 = n_rst;
        send_op(OP_MUL, 16'h00FF, 16'h0100, 32'h0000_FF00, 1'b0, 6, 1'b1);
        drain();
        check("mul_start_cnt", n_start - s0, 1);
        check("mul_rstmul_cnt", n_rst - r0, 1);
        check("mul_rst_before_start", start_cyc - rst_cyc, 1);

        // Assorted ALU ops with d=1
        pe_delay = 1;
        send_op(OP_XOR,  16'hF0F0, 16'h0FF0, 32'h0000_FF00, 1'b0, 4, 1'b1);
        send_op(OP_AND,  16'h00FF, 16'h0F0F, 32'h0000_000F, 1'b0, 4, 1'b1);
        send_op(OP_PASS, 16'h1234, 16'hFFFF, 32'h0000_1234, 1'b0, 4, 1'b1);
        drain();

        // NOP: no PE activity, result next cycle, ready again the cycle after
        s0 = n_start; r0 = n_rst;
        send_op(OP_NOP, 16'hAAAA, 16'h5555, 32'h0, 1'b0, 1, 1'b1);
        @(negedge CLK);
        check("nop_out_valid", OUT_VALID, 1);
        check("nop_in_ready_busy", IN_READY, 0);
        @(negedge CLK);
        check("nop_in_ready_again", IN_READY, 1);
        check("nop_start_cnt", n_start - s0, 0);
        check("nop_rstmul_cnt", n_rst - r0, 0);
        drain();

        // Backpressure with a stray PE_DONE during RESP
        pe_delay = 2;
        OUT_READY = 1'b0;
        send_op(OP_ADD, 16'h0100, 16'h0023, 32'h0000_0123, 1'b0, 5, 1'b1);
        begin
            bit seen = 1'b0;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(negedge CLK);
                if (OUT_VALID) seen = 1'b1;
            end
            check("bp_out_valid_seen", seen, 1);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin @(posedge CLK); #1 stray_done = 1'b1; end
            if (k == 2) begin @(posedge CLK); #1 stray_done = 1'b0; end
            @(negedge CLK);
            check("bp_out_valid", OUT_VALID, 1);
            check("bp_out_data",  OUT_DATA,  32'h0000_0123);
            check("bp_in_ready",  IN_READY,  0);
        end
        @(posedge CLK); #1 OUT_READY = 1'b1;
        drain();

        // Asynchronous reset in the first WAIT cycle of a MUL (PE_START high)
        pe_mute = 1'b1;
        send_op(OP_MUL, 16'd7, 16'd9, 32'h0, 1'b0, 0, 1'b0);
        @(negedge CLK); @(negedge CLK); @(negedge CLK);
        check("mid_pe_start_high", PE_START, 1);
        check("mid_pe_a_held", PE_A, 16'd7);
        #1 RSTN = 1'b0;
        #1;
        check("arst_pe_start", PE_START, 0);
        check("arst_rst_mul", RST_MUL, 0);
        check("arst_pe_opab", {PE_OP, PE_A, PE_B}, 0);
        check("arst_out", {OUT_VALID, OUT_ERR, OUT_DATA}, 0);
        check("arst_in_ready", IN_READY, 1);
        @(negedge CLK); @(negedge CLK);
        RSTN = 1'b1; pe_mute = 1'b0;
        pe_delay = 1;
        send_op(OP_SUB, 16'd10, 16'd4, 32'd6, 1'b0, 4, 1'b1);
        drain();

`ifdef PE_ISSUE_TIMEOUT_EN
        // PE never answers: error response after TO WAIT cycles plus one recovery RST_MUL
        pe_mute = 1'b1;
        s0 = n_start; r0 = n_rst;
        send_op(OP_ADD, 16'd1, 16'd2, 32'h0, 1'b1, 2 + TO, 1'b1);
        drain();
        check("to_start_cnt", n_start - s0, 1);
        check("to_rstmul_cnt", n_rst - r0, 1);
        pe_mute = 1'b0;
        pe_delay = 2;
        send_op(OP_ADD, 16'd2, 16'd2, 32'd4, 1'b0, 5, 1'b1);
        drain();
`endif

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
